// File: rtl/multi_cycle_cpu_pkg.sv
// Shared definitions for the multi_cycle_cpu core.
// Contents: opcodes, FSM state encodings, ADD condition codes and the immediate extender.
package multi_cycle_cpu_pkg;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_STORE = 4'b1001;
    localparam logic [3:0] OP_LOAD  = 4'b1010;

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_WB     = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CZ_ALWAYS     = 2'b00,
        CZ_IF_ZERO    = 2'b01,
        CZ_IF_CARRY   = 2'b10,
        CZ_WITH_CARRY = 2'b11
    } cz_t;

    function automatic logic [15:0] sext6(input logic [5:0] imm);
        return {{10{imm[5]}}, imm};
    endfunction

endpackage

// File: rtl/multi_cycle_cpu_regfile8x16.sv
// Eight 16-bit general registers for multi_cycle_cpu.
// Two asynchronous read ports, one synchronous write port; reset loads each register with its own index.
module multi_cycle_cpu_regfile8x16 (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  raddr1,
    input  logic [2:0]  raddr2,
    input  logic [2:0]  waddr,
    input  logic        we,
    input  logic [15:0] wdata,
    output logic [15:0] rdata1,
    output logic [15:0] rdata2
);

    logic [15:0] regs [8];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= 16'(i);
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = regs[raddr1];
    assign rdata2 = regs[raddr2];

endmodule

// File: rtl/multi_cycle_cpu.sv
// 16-bit four-state multicycle core executing ADD, LOAD and STORE.
// Contains an instruction ROM, a data RAM and the register file; datapath internals are exposed as ports.
module multi_cycle_cpu
    import multi_cycle_cpu_pkg::*;
#(
    parameter int    IMEM_DEPTH = 64,
    parameter int    DMEM_DEPTH = 64,
    parameter string IMEM_FILE  = "imem.hex",
    parameter string DMEM_FILE  = ""
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic        memwrite,
    output logic        regwrite,
    output logic [15:0] instr,
    output logic [15:0] srca,
    output logic [15:0] srcb,
    output logic [15:0] result,
    output logic [15:0] aluout,
    output logic [1:0]  state,
    output logic        zero,
    output logic        carry
);

    localparam int IAW = $clog2(IMEM_DEPTH);
    localparam int DAW = $clog2(DMEM_DEPTH);

    logic [15:0] imem [IMEM_DEPTH];
    logic [15:0] dmem [DMEM_DEPTH];

    logic [15:0] pc;
    state_t      st;
    logic        alu_cout;
    logic        cond_pass;

    logic [3:0]  op;
    logic [2:0]  ra, rb, rc;
    logic        cmp;
    cz_t         cz;
    logic [5:0]  imm6;
    logic        is_add, is_load, is_store;
    logic [15:0] rd_a, rd_b;
    logic        cin;
    logic [16:0] sum;

    // Both memories start out zeroed; their contents are supplied by the surrounding environment.
    initial begin
        for (int i = 0; i < IMEM_DEPTH; i++) imem[i] = '0;
        for (int i = 0; i < DMEM_DEPTH; i++) dmem[i] = '0;
    end

    assign op       = instr[15:12];
    assign ra       = instr[11:9];
    assign rb       = instr[8:6];
    assign rc       = instr[5:3];
    assign cmp      = instr[2];
    assign cz       = cz_t'(instr[1:0]);
    assign imm6     = instr[5:0];
    assign is_add   = (op == OP_ADD);
    assign is_load  = (op == OP_LOAD);
    assign is_store = (op == OP_STORE);

    multi_cycle_cpu_regfile8x16 u_rf (
        .clk    (clk),
        .reset  (reset),
        .raddr1 (ra),
        .raddr2 (rb),
        .waddr  (is_load ? ra : rc),
        .we     (regwrite),
        .wdata  (result),
        .rdata1 (rd_a),
        .rdata2 (rd_b)
    );

    assign cin       = is_add && (cz == CZ_WITH_CARRY) && carry;
    assign sum       = {1'b0, srca} + {1'b0, srcb} + {16'd0, cin};
    assign readdata  = dmem[aluout[DAW-1:0]];
    assign writedata = rd_a;
    assign state     = st;
    assign regwrite  = (st == S_WB) && ((is_add && cond_pass) || is_load);
    assign memwrite  = (st == S_WB) && is_store;
    assign result    = is_load ? readdata : aluout;

    always_ff @(posedge clk) begin
        if (reset) begin
            st        <= S_FETCH;
            pc        <= '0;
            instr     <= '0;
            srca      <= '0;
            srcb      <= '0;
            aluout    <= '0;
            alu_cout  <= 1'b0;
            cond_pass <= 1'b0;
            carry     <= 1'b0;
            zero      <= 1'b0;
        end else begin
            case (st)
                S_FETCH: begin
                    instr <= imem[pc[IAW-1:0]];
                    pc    <= pc + 16'd1;
                    st    <= S_DECODE;
                end
                S_DECODE: begin
                    if (is_add) begin
                        srca <= rd_a;
                        srcb <= cmp ? ~rd_b : rd_b;
                    end else if (is_load || is_store) begin
                        srca <= rd_b;
                        srcb <= sext6(imm6);
                    end
                    st <= S_EXEC;
                end
                S_EXEC: begin
                    aluout    <= sum[15:0];
                    alu_cout  <= sum[16];
                    cond_pass <= (cz == CZ_IF_CARRY) ? carry :
                                 (cz == CZ_IF_ZERO)  ? zero  : 1'b1;
                    st        <= S_WB;
                end
                S_WB: begin
                    // A skipped conditional ADD must leave both flags untouched.
                    if (is_add && cond_pass) begin
                        carry <= alu_cout;
                        zero  <= (aluout == 16'd0);
                    end else if (is_load) begin
                        zero  <= (readdata == 16'd0);
                    end
                    st <= S_FETCH;
                end
                default: st <= S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && memwrite) begin
            dmem[aluout[DAW-1:0]] <= writedata;
        end
    end

endmodule

// File: tb/tb_multi_cycle_cpu.sv
// Self-checking bench for multi_cycle_cpu: single-instruction vector table plus hand-written
// sequences for chained ADDs, conditional execution and reset landing mid-instruction.
module tb_multi_cycle_cpu;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] writedata, readdata, instr, srca, srcb, result, aluout;
    logic        memwrite, regwrite, zero, carry;
    logic [1:0]  state;

    int checks = 0;
    int errors = 0;

    multi_cycle_cpu #(
        .IMEM_DEPTH (64),
        .DMEM_DEPTH (64),
        .IMEM_FILE  (""),
        .DMEM_FILE  ("")
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .writedata (writedata),
        .readdata  (readdata),
        .memwrite  (memwrite),
        .regwrite  (regwrite),
        .instr     (instr),
        .srca      (srca),
        .srcb      (srcb),
        .result    (result),
        .aluout    (aluout),
        .state     (state),
        .zero      (zero),
        .carry     (carry)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        string       name;
        logic [15:0] instr;
        int          mem_addr;
        logic [15:0] mem_init;
        logic        chk_alu;
        logic [15:0] exp_aluout;
        logic [15:0] exp_result;
        logic [15:0] exp_writedata;
        logic        exp_regwrite;
        logic        exp_memwrite;
        int          reg_idx;
        logic [15:0] exp_reg;
        logic [15:0] exp_mem;
        logic        exp_carry;
        logic        exp_zero;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(string name, logic [15:0] ins, int maddr, logic [15:0] minit,
                                logic chk, logic [15:0] alu, logic [15:0] res, logic [15:0] wd,
                                logic rw, logic mw, int ridx, logic [15:0] rval,
                                logic [15:0] mval, logic c, logic z);
        vec_t v;
        v.name = name;        v.instr = ins;         v.mem_addr = maddr;  v.mem_init = minit;
        v.chk_alu = chk;      v.exp_aluout = alu;    v.exp_result = res;  v.exp_writedata = wd;
        v.exp_regwrite = rw;  v.exp_memwrite = mw;   v.reg_idx = ridx;    v.exp_reg = rval;
        v.exp_mem = mval;     v.exp_carry = c;       v.exp_zero = z;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic runCycles(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic fillNop();
        for (int k = 0; k < 64; k++) dut.imem[k] = 16'hF000;
    endtask

    // Holds reset for two edges, then releases it on a falling edge with the core in FETCH.
    task automatic startRun();
        reset = 1'b1;
        runCycles(2);
        reset = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        reset = 1'b1;
        fillNop();
        dut.imem[0] = v.instr;
        dut.dmem[v.mem_addr] = v.mem_init;
        startRun();
        runCycles(3);
        checkOutput({v.name, " state"}, 16'(state), 16'd3);
        if (v.chk_alu) begin
            checkOutput({v.name, " aluout"}, aluout, v.exp_aluout);
            checkOutput({v.name, " result"}, result, v.exp_result);
        end
        checkOutput({v.name, " writedata"}, writedata, v.exp_writedata);
        checkOutput({v.name, " regwrite"}, 16'(regwrite), 16'(v.exp_regwrite));
        checkOutput({v.name, " memwrite"}, 16'(memwrite), 16'(v.exp_memwrite));
        runCycles(1);
        checkOutput({v.name, " reg"}, dut.u_rf.regs[v.reg_idx], v.exp_reg);
        checkOutput({v.name, " mem"}, dut.dmem[v.mem_addr], v.exp_mem);
        checkOutput({v.name, " carry"}, 16'(carry), 16'(v.exp_carry));
        checkOutput({v.name, " zero"}, 16'(zero), 16'(v.exp_zero));
        checkOutput({v.name, " pc"}, dut.pc, 16'd1);
    endtask

    int          seq_ridx[4] = '{1, 1, 7, 7};
    logic [15:0] seq_rval[4] = '{16'd6, 16'd10, 16'd13, 16'd26};
    logic [15:0] b_prog[5]   = '{16'h021C, 16'h050A, 16'h0509, 16'h021C, 16'h050B};
    int          b_ridx[5]   = '{3, 1, 1, 3, 1};
    logic [15:0] b_rval[5]   = '{16'd0, 16'd6, 16'd6, 16'd5, 16'd7};
    logic        b_rw[5]     = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic        b_c[5]      = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic        b_z[5]      = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    initial begin
        //             name        instr     addr init     chk  aluout    result    wdata    rw   mw   reg  regval    memval    c     z
        vecs[0]  = mk("add_r4",   16'h02A0, 0,  16'h0000, 1'b1, 16'h0003, 16'h0003, 16'h0001, 1'b1, 1'b0, 4, 16'h0003, 16'h0000, 1'b0, 1'b0);
        vecs[1]  = mk("add_r1",   16'h0508, 0,  16'h0000, 1'b1, 16'h0006, 16'h0006, 16'h0002, 1'b1, 1'b0, 1, 16'h0006, 16'h0000, 1'b0, 1'b0);
        vecs[2]  = mk("add_cmp",  16'h021C, 0,  16'h0000, 1'b1, 16'h0000, 16'h0000, 16'h0001, 1'b1, 1'b0, 3, 16'h0000, 16'h0000, 1'b1, 1'b1);
        vecs[3]  = mk("load_nz",  16'hA281, 3,  16'h1234, 1'b1, 16'h0003, 16'h1234, 16'h0001, 1'b1, 1'b0, 1, 16'h1234, 16'h1234, 1'b0, 1'b0);
        vecs[4]  = mk("load_z",   16'hA281, 3,  16'h0000, 1'b1, 16'h0003, 16'h0000, 16'h0001, 1'b1, 1'b0, 1, 16'h0000, 16'h0000, 1'b0, 1'b1);
        vecs[5]  = mk("store",    16'h9C4C, 13, 16'h0000, 1'b1, 16'h000D, 16'h000D, 16'h0006, 1'b0, 1'b1, 6, 16'h0006, 16'h0006, 1'b0, 1'b0);
        vecs[6]  = mk("skip_c",   16'h050A, 0,  16'h0000, 1'b1, 16'h0006, 16'h0006, 16'h0002, 1'b0, 1'b0, 1, 16'h0001, 16'h0000, 1'b0, 1'b0);
        vecs[7]  = mk("skip_z",   16'h0509, 0,  16'h0000, 1'b1, 16'h0006, 16'h0006, 16'h0002, 1'b0, 1'b0, 1, 16'h0001, 16'h0000, 1'b0, 1'b0);
        vecs[8]  = mk("addc0",    16'h050B, 0,  16'h0000, 1'b1, 16'h0006, 16'h0006, 16'h0002, 1'b1, 1'b0, 1, 16'h0006, 16'h0000, 1'b0, 1'b0);
        vecs[9]  = mk("nop",      16'hF2A0, 0,  16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h0001, 1'b0, 1'b0, 4, 16'h0004, 16'h0000, 1'b0, 1'b0);
        vecs[10] = mk("carry_nz", 16'h0E54, 0,  16'h0000, 1'b1, 16'h0005, 16'h0005, 16'h0007, 1'b1, 1'b0, 2, 16'h0005, 16'h0000, 1'b1, 1'b0);
        vecs[11] = mk("load_neg", 16'hA2BF, 1,  16'hBEEF, 1'b1, 16'h0001, 16'hBEEF, 16'h0001, 1'b1, 1'b0, 1, 16'hBEEF, 16'hBEEF, 1'b0, 1'b0);
        vecs[12] = mk("store_wr", 16'h9A3F, 63, 16'h0000, 1'b1, 16'hFFFF, 16'hFFFF, 16'h0005, 1'b0, 1'b1, 5, 16'h0005, 16'h0005, 1'b0, 1'b0);

        // Chained ADDs: each result feeds the next instruction's operand read.
        fillNop();
        dut.imem[0] = 16'h0508;
        dut.imem[1] = 16'h0848;
        dut.imem[2] = 16'h0DF8;
        dut.imem[3] = 16'h0FF8;
        startRun();
        checkOutput("chain state0", 16'(state), 16'd0);
        for (int k = 1; k <= 16; k++) begin
            runCycles(1);
            checkOutput($sformatf("chain state c%0d", k), 16'(state), 16'(k % 4));
            checkOutput($sformatf("chain memwrite c%0d", k), 16'(memwrite), 16'd0);
            if (k % 4 == 3) checkOutput($sformatf("chain regwrite c%0d", k), 16'(regwrite), 16'd1);
            if (k % 4 == 0) checkOutput($sformatf("chain reg i%0d", k / 4),
                                        dut.u_rf.regs[seq_ridx[k/4-1]], seq_rval[k/4-1]);
        end
        checkOutput("chain carry", 16'(carry), 16'd0);
        checkOutput("chain zero", 16'(zero), 16'd0);

        // Reset from a dirty state returns every register to its index value.
        reset = 1'b1;
        runCycles(2);
        checkOutput("rst state", 16'(state), 16'd0);
        checkOutput("rst pc", dut.pc, 16'd0);
        checkOutput("rst instr", instr, 16'd0);
        checkOutput("rst srca", srca, 16'd0);
        checkOutput("rst srcb", srcb, 16'd0);
        checkOutput("rst aluout", aluout, 16'd0);
        checkOutput("rst carry", 16'(carry), 16'd0);
        checkOutput("rst zero", 16'(zero), 16'd0);
        checkOutput("rst regwrite", 16'(regwrite), 16'd0);
        checkOutput("rst memwrite", 16'(memwrite), 16'd0);
        for (int r = 0; r < 8; r++)
            checkOutput($sformatf("rst R%0d", r), dut.u_rf.regs[r], 16'(r));

        for (int i = 0; i < 13; i++) applyStimulus(vecs[i]);

        // Conditional execution driven by flags produced earlier in the same program.
        reset = 1'b1;
        fillNop();
        for (int i = 0; i < 5; i++) dut.imem[i] = b_prog[i];
        startRun();
        for (int i = 0; i < 5; i++) begin
            runCycles(3);
            checkOutput($sformatf("cond regwrite i%0d", i), 16'(regwrite), 16'(b_rw[i]));
            runCycles(1);
            checkOutput($sformatf("cond reg i%0d", i), dut.u_rf.regs[b_ridx[i]], b_rval[i]);
            checkOutput($sformatf("cond carry i%0d", i), 16'(carry), 16'(b_c[i]));
            checkOutput($sformatf("cond zero i%0d", i), 16'(zero), 16'(b_z[i]));
            checkOutput($sformatf("cond pc i%0d", i), dut.pc, 16'(i + 1));
        end

        // Reset landing in EXECUTE aborts the ADD; a clean rerun then completes it.
        reset = 1'b1;
        fillNop();
        dut.imem[0] = 16'h0508;
        startRun();
        runCycles(2);
        checkOutput("abort pre state", 16'(state), 16'd2);
        reset = 1'b1;
        runCycles(1);
        checkOutput("abort state", 16'(state), 16'd0);
        checkOutput("abort pc", dut.pc, 16'd0);
        checkOutput("abort aluout", aluout, 16'd0);
        checkOutput("abort R1", dut.u_rf.regs[1], 16'd1);
        reset = 1'b0;
        runCycles(4);
        checkOutput("rerun R1", dut.u_rf.regs[1], 16'd6);

        // Reset on the writeback edge of an ADD suppresses the register write.
        reset = 1'b1;
        startRun();
        runCycles(3);
        checkOutput("wb abort regwrite", 16'(regwrite), 16'd1);
        reset = 1'b1;
        runCycles(1);
        checkOutput("wb abort R1", dut.u_rf.regs[1], 16'd1);
        checkOutput("wb abort state", 16'(state), 16'd0);

        // Reset on the writeback edge of a STORE suppresses the memory write.
        fillNop();
        dut.imem[0] = 16'h9C4C;
        dut.dmem[13] = 16'hAAAA;
        startRun();
        runCycles(3);
        checkOutput("st abort memwrite", 16'(memwrite), 16'd1);
        reset = 1'b1;
        runCycles(1);
        checkOutput("st abort mem", dut.dmem[13], 16'hAAAA);
        checkOutput("st abort state", 16'(state), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
